// File: rtl/force_arb_pkg.sv
// force_arb_pkg: shared types, default sizes and the round-robin pick function
// used by the force_arbiter override scheduler.
package force_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_REL  = 2'd2
    } state_e;

    localparam int NREQ_DEF  = 4;
    localparam int LEN_W_DEF = 4;

    // The picker works on a fixed 8-wide vector so one function serves every NREQ in 2..8.
    localparam int RR_MAX   = 8;
    localparam int RR_IDX_W = 3;

    // First set request at or after ptr, wrapping modulo nreq. Returns 0 when nothing is set.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] ptr,
        input logic [3:0]          nreq
    );
        logic [RR_IDX_W-1:0] win;
        logic                found;
        logic [3:0]          cand;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            // ptr < nreq and k < nreq, so a single subtraction is enough to wrap.
            if (cand >= nreq) begin
                cand = cand - nreq;
            end else begin
                cand = cand;
            end
            if (!found && (4'(k) < nreq) && req[cand[RR_IDX_W-1:0]]) begin
                win   = cand[RR_IDX_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/force_arb_rr.sv
// force_arb_rr: combinational round-robin picker. Returns the first requester
// at or after rr_ptr_i (wrapping) and whether any requester is asking.
module force_arb_rr
    import force_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
    output logic                    valid_o,
    output logic [$clog2(NREQ)-1:0] index_o
);

    localparam int IDX_W = $clog2(NREQ);

    logic [RR_MAX-1:0]   req_ext_s;
    logic [RR_IDX_W-1:0] ptr_ext_s;
    logic [RR_IDX_W-1:0] pick_s;

    // Widen the request/pointer to the function's fixed size and pick the winner.
    always_comb begin
        req_ext_s              = '0;
        req_ext_s[NREQ-1:0]    = req_i;
        ptr_ext_s              = '0;
        ptr_ext_s[IDX_W-1:0]   = rr_ptr_i;
        pick_s                 = rr_pick(req_ext_s, ptr_ext_s, 4'(NREQ));
        valid_o                = |req_i;
        index_o                = pick_s[IDX_W-1:0];
    end

endmodule

// File: rtl/force_arbiter.sv
// force_arbiter: owns the x/y/z/or toggle-shift datapath and lets one of NREQ
// requesters at a time force y_q for a programmed number of cycles.
// Grant/hold/release sequencing is an IDLE -> HOLD -> REL FSM with registered
// outputs, so grant/force_en appear one edge after the FSM enters HOLD.
// Optional feature: define FORCE_ARB_ABORT_EN to let the owner end its hold
// early by dropping its request; by default the hold always runs its full length.
module force_arbiter
    import force_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_val,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         grant,
    output logic                    force_en,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic                    x_q,
    output logic                    y_q,
    output logic                    z_q,
    output logic                    or_q
);

    localparam int                IDX_W     = $clog2(NREQ);
    localparam logic [NREQ-1:0]   GRANT_ONE = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NREQ - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               val_q;
    logic [LEN_W-1:0]   cnt_q;

    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [LEN_W-1:0]   sel_len_s;
    logic [LEN_W-1:0]   load_len_s;
    logic               sel_val_s;
    logic               abort_s;

    force_arb_rr #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid_s),
        .index_o  (pick_idx_s)
    );

    // Select the candidate's value/length; a zero length still holds for one cycle.
    always_comb begin
        sel_len_s  = req_len[int'(pick_idx_s)*LEN_W +: LEN_W];
        sel_val_s  = req_val[pick_idx_s];
        if (sel_len_s == '0) begin
            load_len_s = LEN_ONE;
        end else begin
            load_len_s = sel_len_s;
        end
    end

    // Early-termination request from the current owner (only when the abort feature is built in).
    always_comb begin
`ifdef FORCE_ARB_ABORT_EN
        abort_s = ~req[idx_q];
`else
        abort_s = 1'b0;
`endif
    end

    // Grant/hold/release FSM; outputs are registered from the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            val_q    <= 1'b0;
            cnt_q    <= '0;
            grant    <= '0;
            force_en <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            grant    <= '0;
            force_en <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        idx_q   <= pick_idx_s;
                        val_q   <= sel_val_s;
                        cnt_q   <= load_len_s;
                        state_q <= ST_HOLD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    grant    <= GRANT_ONE << idx_q;
                    force_en <= 1'b1;
                    if (abort_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_REL;
                    end else if (cnt_q <= LEN_ONE) begin
                        cnt_q   <= '0;
                        state_q <= ST_REL;
                    end else begin
                        cnt_q   <= cnt_q - LEN_ONE;
                        state_q <= ST_HOLD;
                    end
                end
                ST_REL: begin
                    done    <= 1'b1;
                    done_id <= idx_q;
                    if (idx_q == IDX_LAST) begin
                        rr_ptr_q <= '0;
                    end else begin
                        rr_ptr_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Toggle/shift datapath with the synchronous y override.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= 1'b0;
            y_q  <= 1'b0;
            z_q  <= 1'b0;
            or_q <= 1'b0;
        end else begin
            x_q  <= run ? ~x_q : x_q;
            y_q  <= force_en ? val_q : x_q;
            z_q  <= x_q;
            or_q <= x_q | y_q;
        end
    end

endmodule

// File: tb/tb_force_arbiter.sv
// tb_force_arbiter: directed stimulus with a scoreboard of expected overrides;
// a monitor checks the datapath every cycle and pops an expectation on each done.
module tb_force_arbiter;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
`ifdef FORCE_ARB_ABORT_EN
    localparam int ABORT_LEN = 3;
`else
    localparam int ABORT_LEN = 8;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       req_val = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ-1:0]       grant;
    logic                  force_en;
    logic                  done;
    logic [1:0]            done_id;
    logic                  x_q, y_q, z_q, or_q;

    always #5 clk = ~clk;

    force_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .run(run), .req(req), .req_val(req_val), .req_len(req_len),
        .grant(grant), .force_en(force_en), .done(done), .done_id(done_id),
        .x_q(x_q), .y_q(y_q), .z_q(z_q), .or_q(or_q)
    );

    typedef struct {
        int   id;
        logic val;
        int   len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference x model and its one-cycle-delayed copy
    logic x_m, x_prev_m;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            x_m      <= 1'b0;
            x_prev_m <= 1'b0;
        end else begin
            x_prev_m <= x_m;
            if (run) x_m <= ~x_m;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ovr(input int id, input logic val, input int len);
        exp_t e;
        e.id = id;
        e.val = val;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s act=no_done exp=done", name);
        end
    endtask

    task automatic wait_fe(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (force_en) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s act=no_force_en exp=force_en", name);
        end
    endtask

    // monitor state
    int         fe_cnt;
    logic       fe_prev, done_prev, x_s, y_s, cur_val;
    logic [3:0] oh;

    initial begin
        fe_cnt = 0; fe_prev = 1'b0; done_prev = 1'b0; x_s = 1'b0; y_s = 1'b0; cur_val = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fe_cnt = 0; fe_prev = 1'b0; done_prev = 1'b0; x_s = 1'b0; y_s = 1'b0;
            end else begin
                check("x_q", x_q, x_m);
                check("z_q", z_q, x_prev_m);
                if (fe_prev) check("y_forced", y_q, cur_val);
                else         check("y_follow", y_q, x_prev_m);
                check("or_q", or_q, x_s | y_s);
                if (force_en) begin
                    if (force_en && !fe_prev) check("idle_gap", done_prev, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp_grant act=%b exp=none", grant);
                    end else begin
                        oh = 4'b0001 << sb[0].id;
                        check("grant", grant, oh);
                        cur_val = sb[0].val;
                    end
                    fe_cnt++;
                end else begin
                    check("grant_idle", grant, 0);
                end
                if (done) begin
                    check("fe_at_done", force_en, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexp_done act=%0d exp=none", done_id);
                    end else begin
                        check("done_id", done_id, sb[0].id);
                        check("fe_len", fe_cnt, sb[0].len);
                        void'(sb.pop_front());
                    end
                    fe_cnt = 0;
                end
                fe_prev = force_en; done_prev = done; x_s = x_q; y_s = y_q;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_force_en", force_en, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_xyzo", {x_q, y_q, z_q, or_q}, 0);
        #1 rst = 1'b0;

        // free-running datapath, then x hold with run low
        run = 1'b1;
        repeat (6) @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);

        // all four requesting, len 1: round robin 0,1,2,3,0
        req_val = 4'b0110;
        req_len = 16'h1111;
        expect_ovr(0, 1'b0, 1);
        expect_ovr(1, 1'b1, 1);
        expect_ovr(2, 1'b1, 1);
        expect_ovr(3, 1'b0, 1);
        expect_ovr(0, 1'b0, 1);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) wait_done("rr");
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check("rr_drain", sb.size(), 0);

        // single request 2, value 1, length 3
        req_val = 4'b0100;
        req_len = 16'h0300;
        expect_ovr(2, 1'b1, 3);
        req = 4'b0100;
        wait_done("len3");
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // length 0 behaves as length 1
        req_val = 4'b0010;
        req_len = 16'h0000;
        expect_ovr(1, 1'b1, 1);
        req = 4'b0010;
        wait_done("len0");
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // reset in the 2nd hold cycle of a length-5 grant to requester 3
        req_val = 4'b1000;
        req_len = 16'h5002;
        expect_ovr(3, 1'b1, 5);
        req = 4'b1001;
        wait_fe("pre_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_force_en", force_en, 0);
        check("mid_rst_y", y_q, 0);
        check("mid_rst_done", done, 0);
        sb.delete();
        @(negedge clk);
        expect_ovr(0, 1'b0, 2);
        expect_ovr(3, 1'b1, 5);
        #1 rst = 1'b0;
        wait_done("post_rst0");
        req = 4'b1000;
        wait_done("post_rst3");
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // request dropped after two hold cycles of a length-8 grant
        req_val = 4'b0000;
        req_len = 16'h0080;
        expect_ovr(1, 1'b0, ABORT_LEN);
        req = 4'b0010;
        wait_fe("abort_fe");
        @(negedge clk);
        #1 req = 4'b0000;
        wait_done("abort");
        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
